// File: rtl/multi_cycle_ctrl_if.sv
// +----------------------------------------------------------------------+
// | multi_cycle_ctrl_if : instruction/datapath bus of the MIPS controller |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface multi_cycle_ctrl_if;
  logic [31:0] inst;
  logic        rs_eq_rt;
  logic        step_mode;
  logic        step;
  logic        ir_wen;
  logic        pc_wen;
  logic        rf_wen;
  logic        dm_wen;
  logic [1:0]  pc_sel;
  logic        wb_sel;
  logic [2:0]  state;
  logic        inst_done;
  logic        halted;
  logic [31:0] inst_cnt;

  modport master (
    output inst, rs_eq_rt, step_mode, step,
    input  ir_wen, pc_wen, rf_wen, dm_wen, pc_sel, wb_sel,
    input  state, inst_done, halted, inst_cnt
  );

  modport slave (
    input  inst, rs_eq_rt, step_mode, step,
    output ir_wen, pc_wen, rf_wen, dm_wen, pc_sel, wb_sel,
    output state, inst_done, halted, inst_cnt
  );
endinterface

`default_nettype wire

// File: rtl/multi_cycle_ctrl.sv
// +----------------------------------------------------------------------+
// | multi_cycle_ctrl : multi-cycle MIPS-subset control FSM               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module multi_cycle_ctrl (
  input  logic               clk,
  input  logic               reset,
  multi_cycle_ctrl_if.slave  ctrl_if
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        halted_q;
  logic [31:0] inst_cnt_q;

  logic [5:0] op, funct;
  logic [4:0] rs, sa;
  logic       is_r3, is_shift, is_alu, is_beq, is_bne, is_lw, is_sw, is_j;
  logic       is_legal, taken;
  logic       unused_bits;

  assign op    = ctrl_if.inst[31:26];
  assign rs    = ctrl_if.inst[25:21];
  assign sa    = ctrl_if.inst[10:6];
  assign funct = ctrl_if.inst[5:0];
  assign unused_bits = ^ctrl_if.inst[20:11];

  assign is_r3 = (op == 6'h00) && (sa == 5'd0) &&
                 ((funct == 6'h21) || (funct == 6'h23) || (funct == 6'h2A) ||
                  (funct == 6'h24) || (funct == 6'h25) || (funct == 6'h26) ||
                  (funct == 6'h27));
  assign is_shift = (op == 6'h00) && (rs == 5'd0) &&
                    ((funct == 6'h00) || (funct == 6'h02));
  assign is_alu   = is_r3 || is_shift || (op == 6'h09) || (op == 6'h0F);
  assign is_beq   = (op == 6'h04);
  assign is_bne   = (op == 6'h05);
  assign is_lw    = (op == 6'h23);
  assign is_sw    = (op == 6'h2B);
  assign is_j     = (op == 6'h02);
  assign is_legal = is_alu || is_beq || is_bne || is_lw || is_sw || is_j;
  assign taken    = (is_beq && ctrl_if.rs_eq_rt) || (is_bne && !ctrl_if.rs_eq_rt);

  logic       ir_wen, pc_wen, rf_wen, dm_wen, wb_sel, inst_done;
  logic [1:0] pc_sel;

  always_comb begin
    state_d   = state_q;
    ir_wen    = 1'b0;
    pc_wen    = 1'b0;
    rf_wen    = 1'b0;
    dm_wen    = 1'b0;
    pc_sel    = 2'b00;
    wb_sel    = 1'b0;
    inst_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        // Step pulses are only sampled here, so pulses elsewhere are dropped.
        if (!ctrl_if.step_mode || ctrl_if.step) begin
          ir_wen  = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!is_legal) begin
          state_d = S_HALT;
        end else if (is_j) begin
          pc_wen    = 1'b1;
          pc_sel    = 2'b10;
          inst_done = 1'b1;
          state_d   = S_FETCH;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        if (is_beq || is_bne) begin
          pc_wen    = 1'b1;
          pc_sel    = taken ? 2'b01 : 2'b00;
          inst_done = 1'b1;
          state_d   = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (is_sw) begin
          dm_wen    = 1'b1;
          pc_wen    = 1'b1;
          inst_done = 1'b1;
          state_d   = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        rf_wen    = 1'b1;
        wb_sel    = is_lw;
        pc_wen    = 1'b1;
        inst_done = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      halted_q   <= 1'b0;
      inst_cnt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      halted_q   <= halted_q || (state_d == S_HALT);
      inst_cnt_q <= inst_cnt_q + {31'd0, inst_done};
    end
  end

  // Reset gates the combinational outputs so FETCH cannot raise ir_wen mid-reset.
  assign ctrl_if.ir_wen    = ir_wen    && !reset;
  assign ctrl_if.pc_wen    = pc_wen    && !reset;
  assign ctrl_if.rf_wen    = rf_wen    && !reset;
  assign ctrl_if.dm_wen    = dm_wen    && !reset;
  assign ctrl_if.inst_done = inst_done && !reset;
  assign ctrl_if.pc_sel    = reset ? 2'b00 : pc_sel;
  assign ctrl_if.wb_sel    = wb_sel && !reset;
  assign ctrl_if.state     = state_q;
  assign ctrl_if.halted    = halted_q;
  assign ctrl_if.inst_cnt  = inst_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_multi_cycle_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_multi_cycle_ctrl : scoreboard bench for multi_cycle_ctrl          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_multi_cycle_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multi_cycle_ctrl_if bus ();

  multi_cycle_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .ctrl_if (bus)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       ir;
    logic       pc;
    logic       rf;
    logic       dm;
    logic [1:0] psel;
    logic       wb;
    logic       done;
  } row_t;

  localparam int C_ILL = 0, C_ALU = 1, C_BR = 2, C_LW = 3, C_SW = 4, C_J = 5;

  row_t        sbq[$];
  int          checks = 0;
  int          passes = 0;
  logic [31:0] cnt_m;

  function automatic row_t mk(input logic [2:0] st, input logic ir, input logic pc,
                              input logic rf, input logic dm, input logic [1:0] psel,
                              input logic wb, input logic done);
    row_t r;
    r = {st, ir, pc, rf, dm, psel, wb, done};
    return r;
  endfunction

  function automatic row_t observe();
    row_t r;
    r = {bus.state, bus.ir_wen, bus.pc_wen, bus.rf_wen, bus.dm_wen,
         bus.pc_sel, bus.wb_sel, bus.inst_done};
    return r;
  endfunction

  function automatic int classify(input logic [31:0] w);
    logic [5:0] op, fn;
    op = w[31:26];
    fn = w[5:0];
    if (op == 6'h00) begin
      if (w[10:6] == 5'd0 && (fn == 6'h21 || fn == 6'h23 || fn == 6'h2A || fn == 6'h24 ||
                              fn == 6'h25 || fn == 6'h26 || fn == 6'h27)) return C_ALU;
      if (w[25:21] == 5'd0 && (fn == 6'h00 || fn == 6'h02)) return C_ALU;
      return C_ILL;
    end
    case (op)
      6'h09, 6'h0F: return C_ALU;
      6'h04, 6'h05: return C_BR;
      6'h23:        return C_LW;
      6'h2B:        return C_SW;
      6'h02:        return C_J;
      default:      return C_ILL;
    endcase
  endfunction

  task automatic push_rows(input logic [31:0] w, input logic eq, input bit with_fetch);
    int   cls;
    logic tk;
    cls = classify(w);
    tk  = (w[31:26] == 6'h04) ? eq : ~eq;
    if (with_fetch) sbq.push_back(mk(3'd0, 1, 0, 0, 0, 2'b00, 0, 0));
    if (cls == C_J) begin
      sbq.push_back(mk(3'd1, 0, 1, 0, 0, 2'b10, 0, 1));
    end else begin
      sbq.push_back(mk(3'd1, 0, 0, 0, 0, 2'b00, 0, 0));
    end
    case (cls)
      C_BR:  sbq.push_back(mk(3'd2, 0, 1, 0, 0, tk ? 2'b01 : 2'b00, 0, 1));
      C_ALU: begin
        sbq.push_back(mk(3'd2, 0, 0, 0, 0, 2'b00, 0, 0));
        sbq.push_back(mk(3'd4, 0, 1, 1, 0, 2'b00, 0, 1));
      end
      C_SW: begin
        sbq.push_back(mk(3'd2, 0, 0, 0, 0, 2'b00, 0, 0));
        sbq.push_back(mk(3'd3, 0, 1, 0, 1, 2'b00, 0, 1));
      end
      C_LW: begin
        sbq.push_back(mk(3'd2, 0, 0, 0, 0, 2'b00, 0, 0));
        sbq.push_back(mk(3'd3, 0, 0, 0, 0, 2'b00, 0, 0));
        sbq.push_back(mk(3'd4, 0, 1, 1, 0, 2'b00, 1, 1));
      end
      default: ;
    endcase
    if (cls != C_ILL) cnt_m = cnt_m + 32'd1;
  endtask

  task automatic drain_n(input string name, input int n);
    row_t e, g;
    for (int i = 0; i < n && sbq.size() > 0; i++) begin
      @(negedge clk);
      e = sbq.pop_front();
      g = observe();
      checks++;
      if (g !== e) $display("FAIL %s row %0d: got %b exp %b (st,ir,pc,rf,dm,psel,wb,done)", name, i, g, e);
      else passes++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_cnt(input string name);
    checks++;
    if (bus.inst_cnt !== cnt_m) $display("FAIL %s inst_cnt: got %h exp %h", name, bus.inst_cnt, cnt_m);
    else passes++;
  endtask

  task automatic run(input string name, input logic [31:0] w, input logic eq);
    bus.inst     = w;
    bus.rs_eq_rt = eq;
    push_rows(w, eq, 1'b1);
    drain_n(name, 16);
    check_cnt(name);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    cnt_m = 32'd0;
    sbq.delete();
  endtask

  task automatic test_reset();
    row_t g;
    reset = 1'b1;
    bus.step_mode = 1'b0;
    bus.step      = 1'b0;
    bus.rs_eq_rt  = 1'b0;
    bus.inst      = 32'h0022_1821;
    cnt_m         = 32'd0;
    repeat (2) @(negedge clk);
    g = observe();
    checks++;
    if (g !== '0 || bus.halted !== 1'b0 || bus.inst_cnt !== 32'd0)
      $display("FAIL reset outputs: got %b halted %b cnt %h exp all zero", g, bus.halted, bus.inst_cnt);
    else passes++;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_alu();
    run("addu",  32'h0022_1821, 1'b0);
    run("subu",  32'h0022_1823, 1'b0);
    run("sll",   32'h0002_1080, 1'b0);
    run("addiu", 32'h2401_0005, 1'b0);
    run("lui",   32'h3C01_1234, 1'b0);
  endtask

  task automatic test_mem();
    run("lw", 32'h8C01_0004, 1'b0);
    run("sw", 32'hAC01_0008, 1'b0);
  endtask

  task automatic test_branch();
    run("beq_t",  32'h1022_0003, 1'b1);
    run("bne_nt", 32'h1422_0003, 1'b1);
    run("beq_nt", 32'h1022_0003, 1'b0);
    run("bne_t",  32'h1422_0003, 1'b0);
    run("j",      32'h0800_0010, 1'b0);
  endtask

  task automatic test_wrap();
    bus.inst = 32'h0800_0010;
    force dut.inst_cnt_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 release dut.inst_cnt_q;
    cnt_m = 32'hFFFF_FFFF;
    push_rows(32'h0800_0010, 1'b0, 1'b0);
    drain_n("wrap", 16);
    checks++;
    if (bus.inst_cnt !== 32'd0 || cnt_m !== 32'd0)
      $display("FAIL wrap inst_cnt: got %h exp 00000000", bus.inst_cnt);
    else passes++;
  endtask

  task automatic test_step();
    row_t e, g;
    bus.inst      = 32'h0022_1821;
    bus.step_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (observe() !== '0) $display("FAIL step_hold cycle %0d: got %b exp all zero", i, observe());
      else passes++;
      @(posedge clk);
      #1;
    end
    push_rows(32'h0022_1821, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      bus.step = (i == 0 || i == 2);
      @(negedge clk);
      e = sbq.pop_front();
      g = observe();
      checks++;
      if (g !== e) $display("FAIL step_inst row %0d: got %b exp %b", i, g, e);
      else passes++;
      @(posedge clk);
      #1;
    end
    bus.step = 1'b0;
    check_cnt("step");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (observe() !== '0) $display("FAIL step_no_queue cycle %0d: got %b exp all zero", i, observe());
      else passes++;
      @(posedge clk);
      #1;
    end
    bus.step_mode = 1'b0;
    run("after_step", 32'h0022_1821, 1'b0);
  endtask

  task automatic test_reset_mid();
    bus.inst = 32'h8C01_0004;
    push_rows(32'h8C01_0004, 1'b0, 1'b1);
    drain_n("lw_pre", 3);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.state !== 3'd0 || bus.rf_wen !== 1'b0 || bus.pc_wen !== 1'b0 ||
        bus.inst_done !== 1'b0 || bus.inst_cnt !== 32'd0)
      $display("FAIL reset_mid: got st %0d rf %b pc %b done %b cnt %h exp 0 0 0 0 0",
               bus.state, bus.rf_wen, bus.pc_wen, bus.inst_done, bus.inst_cnt);
    else passes++;
    sbq.delete();
    cnt_m = 32'd0;
    @(posedge clk);
    #1 reset = 1'b0;
    run("after_reset", 32'h0022_1821, 1'b0);
  endtask

  task automatic test_halt();
    bus.inst = 32'hFC00_0000;
    push_rows(32'hFC00_0000, 1'b0, 1'b1);
    drain_n("illegal", 16);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (observe() !== mk(3'd5, 0, 0, 0, 0, 2'b00, 0, 0) || bus.halted !== 1'b1)
        $display("FAIL halt cycle %0d: got %b halted %b exp st 5 quiet halted 1", i, observe(), bus.halted);
      else passes++;
    end
    check_cnt("halt");
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.state !== 3'd0 || bus.halted !== 1'b0)
      $display("FAIL halt_reset: got st %0d halted %b exp 0 0", bus.state, bus.halted);
    else passes++;
    @(posedge clk);
    #1 reset = 1'b0;
    cnt_m = 32'd0;
    sbq.delete();
    bus.inst = 32'h0022_1861;
    push_rows(32'h0022_1861, 1'b0, 1'b1);
    drain_n("illegal_r", 16);
    @(negedge clk);
    checks++;
    if (bus.state !== 3'd5 || bus.halted !== 1'b1)
      $display("FAIL illegal_r halt: got st %0d halted %b exp 5 1", bus.state, bus.halted);
    else passes++;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_wrap();
    test_step();
    test_reset_mid();
    test_halt();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: inst  input  32  instruction register contents, stable from DECODE through end of instruction.
REQ-004 SHALL have port: rs_eq_rt  input  1  datapath compare result, GPR[rs]==GPR[rt].
REQ-005 SHALL have port: step_mode  input  1  1 = single-step operation.
REQ-006 SHALL have port: step  input  1  one-cycle step pulse, already synchronised to clk.
REQ-007 SHALL have ports: ir_wen, pc_wen, rf_wen, dm_wen  output  1 each  register/memory write enables.
REQ-008 SHALL have port: pc_sel  output  2  next-PC select: 00 seq_pc, 01 branch target, 10 jump target.
REQ-009 SHALL have port: wb_sel  output  1  regfile write data: 0 ALU result, 1 memory read data.
REQ-010 SHALL have ports: state  output  3  current state code; inst_done  output  1  retire pulse; halted  output  1  sticky illegal-instruction flag; inst_cnt  output  32  retired-instruction count.

Function
REQ-011 SHALL implement states FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4, HALT=5; codes 6-7 unreachable and SHALL map to FETCH.
REQ-012 SHALL decode exactly ADDU, SUBU, SLT, AND, NOR, OR, XOR (op=0, sa=0), SLL, SRL (op=0, rs=0), ADDIU, BEQ, BNE, LW, SW, LUI, J, using standard MIPS opcode/funct encodings; any other word is illegal.
REQ-013 FETCH: ir_wen=1 for one cycle, then DECODE; when step_mode=1, SHALL hold in FETCH with ir_wen=0 until a cycle with step=1.
REQ-014 DECODE: illegal -> HALT; J -> pc_wen=1, pc_sel=10, inst_done=1, then FETCH; all others -> EXE.
REQ-015 EXE: BEQ/BNE -> pc_wen=1, pc_sel=01 if taken (BEQ & rs_eq_rt | BNE & ~rs_eq_rt), else 00; inst_done=1; then FETCH. LW/SW -> MEM; ALU-class (R-type, ADDIU, LUI) -> WB.
REQ-016 MEM: SW -> dm_wen=1, pc_wen=1, pc_sel=00, inst_done=1, then FETCH; LW -> WB.
REQ-017 WB: rf_wen=1, wb_sel=1 for LW, otherwise 0; pc_wen=1, pc_sel=00, inst_done=1; then FETCH.
REQ-018 Latency from FETCH entry to retirement, in cycles: J 2; BEQ/BNE 3; ALU-class 4; SW 4; LW 5.
REQ-019 All enables SHALL be 0 in every state/instruction combination not listed; at most one of rf_wen/dm_wen SHALL be high in any cycle; pc_wen SHALL be high exactly once per retired instruction.
REQ-020 HALT: all enables 0, halted=1; state SHALL be held until reset.
REQ-021 inst_cnt SHALL increment by 1 on each inst_done cycle and wrap from 0xFFFFFFFF to 0.
REQ-022 A step pulse outside FETCH, or while step_mode=0, SHALL be ignored and not queued; a change of step_mode SHALL take effect only in FETCH.
REQ-023 Enable outputs and inst_done SHALL be combinational from state, inst and rs_eq_rt; state, halted and inst_cnt SHALL be registers.

Reset
REQ-024 On reset assertion, SHALL immediately (asynchronously) enter FETCH, clear halted and inst_cnt, and abandon any in-flight instruction without completing its writes.
REQ-025 While reset=1, ir_wen, pc_wen, rf_wen, dm_wen and inst_done SHALL be forced to 0; pc_sel=00, wb_sel=0, state=0.
REQ-026 On the first rising clk edge after reset deasserts, SHALL act as FETCH, with ir_wen=1 unless step_mode=1.

Verification
REQ-027 ADDU sequence (inst=0x00221821) from reset -> states 0,1,2,4; rf_wen=1 only in WB; pc_wen=1, pc_sel=00 in WB; inst_cnt=1.
REQ-028 LW (0x8C010004) followed by SW (0xAC010008) -> LW retires after 5 cycles with wb_sel=1 in WB; SW retires after 4 cycles with dm_wen=1 in MEM only; inst_cnt=2.
REQ-029 BEQ with rs_eq_rt=1, then BNE with rs_eq_rt=1 -> first pc_sel=01, second pc_sel=00; each retires in 3 cycles; J retires in 2 cycles with pc_sel=10.
REQ-030 inst=0xFC000000 -> HALT after DECODE; halted=1; all enables 0 for 20 further cycles; reset then returns to FETCH with halted=0.
REQ-031 step_mode=1 -> FETCH held for 10 cycles with ir_wen=0; a step pulse advances exactly one instruction; a step pulse in EXE has no effect.
REQ-032 Preload inst_cnt to 0xFFFFFFFF via 2^32-1 forced retirements (or a force) and one more retirement -> inst_cnt=0; reset asserted during LW MEM -> no rf_wen, state=0 immediately.
